id_ex_stage: RTL and testbench

Pipeline register between decode and execute in the five-stage RISC-V core. It captures the control word from the main/ALU decoders, together with register operands, immediate, PC values and the branch-predictor tag, and presents them to the execute stage one cycle later. It supports stall (hold) and flush (bubble insertion) from the hazard unit, and carries a valid bit so execute and the predictor-update path ignore killed slots.

---
 rtl/id_ex_stage.sv | 187 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures the decoded control word, operands, PCs and prediction tag.
// Optional bubble/stall statistics counters are built when ID_EX_STAT_EN is defined.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              ValidD,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              BranchD,
  input  logic              ALUSrcD,
  input  logic              JumpD,
  input  logic              jalrD,
  input  logic [1:0]        ResultSrcD,
  input  logic [2:0]        ALUControlD,
  input  logic [2:0]        funct3D,
  input  logic              PredTakenD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  output logic              ValidE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic              JumpE,
  output logic              jalrE,
  output logic [1:0]        ResultSrcE,
  output logic [2:0]        ALUControlE,
  output logic [2:0]        funct3E,
  output logic              PredTakenE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E
`ifdef ID_EX_STAT_EN
  ,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic [31:0]       BubbleCntE,
  output logic [31:0]       StallCntE
`else
  ,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE
`endif
);

  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic              branch;
    logic              alu_src;
    logic              jump;
    logic              jalr;
    logic [1:0]        result_src;
    logic [2:0]        alu_control;
    logic [2:0]        funct3;
    logic              pred_taken;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm_ext;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } payload_t;

  payload_t pay_in;
  payload_t pay_d, pay_q;
  logic     valid_d, valid_q;
  logic     load_bubble;
  logic     load_capture;

  always_comb begin
    pay_in             = '0;
    pay_in.reg_write   = RegWriteD;
    pay_in.mem_write   = MemWriteD;
    pay_in.branch      = BranchD;
    pay_in.alu_src     = ALUSrcD;
    pay_in.jump        = JumpD;
    pay_in.jalr        = jalrD;
    pay_in.result_src  = ResultSrcD;
    pay_in.alu_control = ALUControlD;
    pay_in.funct3      = funct3D;
    pay_in.pred_taken  = PredTakenD;
    pay_in.rd1         = RD1D;
    pay_in.rd2         = RD2D;
    pay_in.imm_ext     = ImmExtD;
    pay_in.pc          = PCD;
    pay_in.pc_plus4    = PCPlus4D;
    pay_in.rs1         = Rs1D;
    pay_in.rs2         = Rs2D;
    pay_in.rd          = RdD;
  end

  // A killed decode slot is loaded exactly like a flush, so downstream never needs extra gating.
  always_comb begin
    load_bubble  = FlushE || (!StallE && !ValidD);
    load_capture = !FlushE && !StallE && ValidD;
    pay_d        = pay_q;
    valid_d      = valid_q;
    if (load_bubble) begin
      pay_d   = '0;
      valid_d = 1'b0;
    end else if (load_capture) begin
      pay_d   = pay_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pay_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pay_q   <= pay_d;
      valid_q <= valid_d;
    end
  end

  assign ValidE      = valid_q;
  assign RegWriteE   = pay_q.reg_write;
  assign MemWriteE   = pay_q.mem_write;
  assign BranchE     = pay_q.branch;
  assign ALUSrcE     = pay_q.alu_src;
  assign JumpE       = pay_q.jump;
  assign jalrE       = pay_q.jalr;
  assign ResultSrcE  = pay_q.result_src;
  assign ALUControlE = pay_q.alu_control;
  assign funct3E     = pay_q.funct3;
  assign PredTakenE  = pay_q.pred_taken;
  assign RD1E        = pay_q.rd1;
  assign RD2E        = pay_q.rd2;
  assign ImmExtE     = pay_q.imm_ext;
  assign PCE         = pay_q.pc;
  assign PCPlus4E    = pay_q.pc_plus4;
  assign Rs1E        = pay_q.rs1;
  assign Rs2E        = pay_q.rs2;
  assign RdE         = pay_q.rd;

`ifdef ID_EX_STAT_EN
  logic [31:0] bubble_cnt_d, bubble_cnt_q;
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic        stall_edge;

  // Both counters saturate rather than wrap so long runs never report a small bogus count.
  always_comb begin
    stall_edge   = StallE && !FlushE;
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (load_bubble && !(&bubble_cnt_q)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
    if (stall_edge && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign BubbleCntE = bubble_cnt_q;
  assign StallCntE  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table-driven control vectors plus hand-written reset/stall/flush sequences.
module tb_id_ex_stage;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int PW     = 15 + 5 * XLEN + 3 * REG_AW;
  localparam int EW     = PW + 1;

  localparam int KIND_CAP  = 0;
  localparam int KIND_HOLD = 1;
  localparam int KIND_ZERO = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic StallE, FlushE, ValidD;
  logic RegWriteD, MemWriteD, BranchD, ALUSrcD, JumpD, jalrD, PredTakenD;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD, funct3D;
  logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [REG_AW-1:0] Rs1D, Rs2D, RdD;
  logic ValidE;
  logic RegWriteE, MemWriteE, BranchE, ALUSrcE, JumpE, jalrE, PredTakenE;
  logic [1:0] ResultSrcE;
  logic [2:0] ALUControlE, funct3E;
  logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
`ifdef ID_EX_STAT_EN
  logic [31:0] BubbleCntE, StallCntE;
`endif

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] prev_exp;

  typedef struct {
    logic stall;
    logic flush;
    logic valid;
    int   kind;
  } vec_t;
  vec_t vecs[16];

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .JumpD(JumpD), .jalrD(jalrD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .funct3D(funct3D), .PredTakenD(PredTakenD), .RD1D(RD1D), .RD2D(RD2D),
    .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .JumpE(JumpE), .jalrE(jalrE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .funct3E(funct3E), .PredTakenE(PredTakenE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
`ifdef ID_EX_STAT_EN
    , .BubbleCntE(BubbleCntE), .StallCntE(StallCntE)
`endif
  );

  function automatic logic [PW-1:0] cur_d();
    return {RegWriteD, MemWriteD, BranchD, ALUSrcD, JumpD, jalrD, ResultSrcD, ALUControlD,
            funct3D, PredTakenD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD};
  endfunction

  function automatic logic [EW-1:0] cur_e();
    return {ValidE, RegWriteE, MemWriteE, BranchE, ALUSrcE, JumpE, jalrE, ResultSrcE,
            ALUControlE, funct3E, PredTakenE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
            Rs1E, Rs2E, RdE};
  endfunction

  task automatic set_d(input logic [PW-1:0] p);
    {RegWriteD, MemWriteD, BranchD, ALUSrcD, JumpD, jalrD, ResultSrcD, ALUControlD,
     funct3D, PredTakenD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD} = p;
  endtask

  task automatic rand_d();
    logic [PW-1:0] p;
    for (int i = 0; i < PW; i++) p[i] = 1'($urandom_range(0, 1));
    set_d(p);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pops the scoreboard and compares the whole registered output word.
  task automatic check_out(input string name);
    logic [EW-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      exp = exp_q.pop_front();
      if (cur_e() !== exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", name, cur_e(), exp);
      end
    end
  endtask

  // Drive controls at the falling edge, push expectation, sample 1ns after the rising edge.
  task automatic apply(input logic s, input logic f, input logic v, input int kind,
                       input string name);
    logic [EW-1:0] exp;
    StallE = s; FlushE = f; ValidD = v;
    case (kind)
      KIND_CAP:  exp = {1'b1, cur_d()};
      KIND_HOLD: exp = prev_exp;
      default:   exp = '0;
    endcase
    exp_q.push_back(exp);
    prev_exp = exp;
    @(posedge clk);
    #1;
    check_out(name);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.push_back('0);
    prev_exp = '0;
    @(posedge clk);
    #1;
    check_out("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b1, KIND_CAP};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, KIND_HOLD};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, KIND_HOLD};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, KIND_ZERO};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, KIND_CAP};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, KIND_ZERO};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, KIND_ZERO};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, KIND_HOLD};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, KIND_CAP};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, KIND_ZERO};
    vecs[10] = '{1'b0, 1'b0, 1'b1, KIND_CAP};
    vecs[11] = '{1'b1, 1'b1, 1'b0, KIND_ZERO};
    vecs[12] = '{1'b0, 1'b0, 1'b1, KIND_CAP};
    vecs[13] = '{1'b1, 1'b0, 1'b1, KIND_HOLD};
    vecs[14] = '{1'b1, 1'b0, 1'b0, KIND_HOLD};
    vecs[15] = '{1'b0, 1'b0, 1'b1, KIND_CAP};

    rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0; ValidD = 1'b1;
    set_d('1);
    prev_exp = '0;
    @(negedge clk);

    // Reset with all inputs high, then release and confirm outputs stay zero until a valid capture.
    do_reset();
    rst_n = 1'b0;
    do_reset();
    apply(1'b0, 1'b0, 1'b0, KIND_ZERO, "post_reset_invalid");
    apply(1'b1, 1'b0, 1'b1, KIND_HOLD, "post_reset_stall");
    chk("post_reset_validE", 32'(ValidE), 32'd0);

    // lw capture.
    set_d('0);
    RegWriteD = 1'b1; ResultSrcD = 2'b01; ALUSrcD = 1'b1;
    RD1D = 32'h1000; ImmExtD = 32'h8; RdD = 5'd5;
    apply(1'b0, 1'b0, 1'b1, KIND_CAP, "lw_capture");
    chk("lw_validE", 32'(ValidE), 32'd1);
    chk("lw_rd1E", RD1E, 32'h1000);
    chk("lw_immE", ImmExtE, 32'h8);
    chk("lw_rdE", 32'(RdE), 32'd5);
    chk("lw_result_srcE", 32'(ResultSrcE), 32'd1);

    // Stall for three cycles while decode moves on.
    RD1D = 32'h2000;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 1'b1, KIND_HOLD, "stall_hold");
      chk("stall_rd1E", RD1E, 32'h1000);
    end
    apply(1'b0, 1'b0, 1'b1, KIND_CAP, "stall_release");
    chk("stall_release_rd1E", RD1E, 32'h2000);

    // Valid branch, then flush and stall together, then stall alone holds the bubble.
    rand_d();
    BranchD = 1'b1; PredTakenD = 1'b1; RdD = 5'd3;
    apply(1'b0, 1'b0, 1'b1, KIND_CAP, "branch_capture");
    chk("branch_branchE", 32'(BranchE), 32'd1);
    chk("branch_predE", 32'(PredTakenE), 32'd1);
    rand_d();
    apply(1'b1, 1'b1, 1'b1, KIND_ZERO, "flush_over_stall");
    chk("flush_validE", 32'(ValidE), 32'd0);
    chk("flush_branchE", 32'(BranchE), 32'd0);
    chk("flush_predE", 32'(PredTakenE), 32'd0);
    chk("flush_rdE", 32'(RdE), 32'd0);
    apply(1'b1, 1'b0, 1'b1, KIND_HOLD, "flush_then_stall");
    apply(1'b1, 1'b0, 1'b1, KIND_HOLD, "flush_then_stall2");

    // Invalid decode slot becomes a bubble.
    rand_d();
    RegWriteD = 1'b1; MemWriteD = 1'b1; RdD = 5'd7;
    apply(1'b0, 1'b0, 1'b0, KIND_ZERO, "invalid_slot");
    chk("invalid_regwriteE", 32'(RegWriteE), 32'd0);
    chk("invalid_memwriteE", 32'(MemWriteE), 32'd0);
    chk("invalid_rdE", 32'(RdE), 32'd0);

    // Table-driven control patterns with random payloads.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) begin
        rand_d();
        apply(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].kind, $sformatf("vec%0d", i));
      end
    end

    // Mid-stream reset drops contents; first edge afterwards evaluates normally.
    rand_d();
    apply(1'b0, 1'b0, 1'b1, KIND_CAP, "pre_reset_capture");
    do_reset();
    apply(1'b1, 1'b0, 1'b1, KIND_HOLD, "after_reset_stall");
    rand_d();
    apply(1'b0, 1'b0, 1'b1, KIND_CAP, "after_reset_capture");

`ifdef ID_EX_STAT_EN
    do_reset();
    chk("stat_reset_bubble", BubbleCntE, 32'd0);
    chk("stat_reset_stall", StallCntE, 32'd0);
    apply(1'b0, 1'b1, 1'b1, KIND_ZERO, "stat_flush1");
    apply(1'b0, 1'b1, 1'b1, KIND_ZERO, "stat_flush2");
    apply(1'b0, 1'b0, 1'b0, KIND_ZERO, "stat_invalid");
    for (int i = 0; i < 4; i++) apply(1'b1, 1'b0, 1'b1, KIND_HOLD, "stat_stall");
    chk("stat_bubble_cnt", BubbleCntE, 32'd3);
    chk("stat_stall_cnt", StallCntE, 32'd4);
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    force dut.stall_cnt_q  = 32'hFFFF_FFFF;
    #1;
    release dut.bubble_cnt_q;
    release dut.stall_cnt_q;
    apply(1'b0, 1'b1, 1'b1, KIND_ZERO, "stat_sat_flush");
    apply(1'b1, 1'b0, 1'b1, KIND_HOLD, "stat_sat_stall");
    chk("stat_bubble_sat", BubbleCntE, 32'hFFFF_FFFF);
    chk("stat_stall_sat", StallCntE, 32'hFFFF_FFFF);
`endif

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
